sample_requantize: RTL

- Output-side counterpart of the overdrive gain stage.
- Takes the 32-bit fixed-point product (bits_per_level fractional bits) and returns it to a 16-bit signed audio sample by rounding and saturating.
- Tracks clipping and peak level for the UI/LED path.
- Sits between the gain/shaper chain and the codec TX stream, with a 2-stage valid/ready pipeline.

---
 rtl/sample_requantize.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sample_requantize.sv
// Rounds and saturates a fixed-point product back to a 16-bit sample through a
// 2-stage valid/ready pipeline, tracking clip hold, clip count and a decaying peak.
module sample_requantize #(
  parameter int bits_per_level   = 12,
  parameter int CLIP_HOLD        = 4800,
  parameter int PEAK_DECAY_SHIFT = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_sample,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_sample,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_clip,
  output logic [15:0] o_clip_count,
  input  logic        i_clip_clear,
  output logic [15:0] o_peak
);

  localparam int HOLD_W = $clog2(CLIP_HOLD + 1);
  localparam logic signed [32:0] HALF = 33'sd1 <<< (bits_per_level - 1);
  localparam logic signed [32:0] POS_MAX = 33'sd32767;
  localparam logic signed [32:0] NEG_MIN = -33'sd32768;

  logic                    advance;
  logic                    xfer_out;
  logic                    s1_valid;
  logic signed [32:0]      s1_r;
  logic signed [32:0]      sum;
  logic signed [32:0]      r_in;
  logic [15:0]             sat_sample;
  logic                    sat_clip;
  logic                    clip_flag;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [15:0]             mag;
  logic [15:0]             decay;
  logic [15:0]             decayed;
  logic [15:0]             peak_next;

  assign advance  = !o_valid || i_ready;
  assign o_ready  = !s1_valid || advance;
  assign xfer_out = o_valid && i_ready;
  assign o_clip   = (hold_cnt != '0);

  // 33-bit headroom keeps the rounding offset from overflowing at full scale
  assign sum  = $signed({i_sample[31], i_sample}) + HALF;
  assign r_in = sum >>> bits_per_level;

  always_comb begin
    sat_sample = s1_r[15:0];
    sat_clip   = 1'b0;
    if (s1_r > POS_MAX) begin
      sat_sample = 16'h7FFF;
      sat_clip   = 1'b1;
    end else if (s1_r < NEG_MIN) begin
      sat_sample = 16'h8000;
      sat_clip   = 1'b1;
    end
  end

  // |-32768| is reported as 32767 so the meter stays within 15 bits of magnitude
  always_comb begin
    mag = o_sample;
    if (o_sample[15]) begin
      mag = (o_sample == 16'h8000) ? 16'h7FFF : (~o_sample + 16'd1);
    end
    decay = o_peak >> PEAK_DECAY_SHIFT;
    if (decay == 16'd0 && o_peak != 16'd0) begin
      decay = 16'd1;
    end
    decayed   = o_peak - decay;
    peak_next = (mag > decayed) ? mag : decayed;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid     <= 1'b0;
      s1_r         <= '0;
      o_valid      <= 1'b0;
      o_sample     <= '0;
      clip_flag    <= 1'b0;
      hold_cnt     <= '0;
      o_clip_count <= '0;
      o_peak       <= '0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_r <= r_in;
        end
      end
      if (advance) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_sample  <= sat_sample;
          clip_flag <= sat_clip;
        end
      end
      // clear wins over a clipped transfer in the same cycle
      if (i_clip_clear) begin
        o_clip_count <= '0;
        hold_cnt     <= '0;
      end else if (xfer_out) begin
        if (clip_flag) begin
          hold_cnt <= HOLD_W'(CLIP_HOLD);
          if (o_clip_count != 16'hFFFF) begin
            o_clip_count <= o_clip_count + 16'd1;
          end
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end
      if (xfer_out) begin
        o_peak <= peak_next;
      end
    end
  end

endmodule
